// File: rtl/fsm_monitor_pkg.sv
// Shared widths, transition-record type and saturating counter helper for the FSM state monitor.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package fsm_monitor_pkg;

    localparam int STATE_W       = 2;
    localparam int COUNT_W       = 16;
    localparam int LOG_DEPTH_DEF = 4;

    // One logged transition: where the FSM came from, where it went, and how
    // long it had sat in the source state before leaving.
    typedef struct packed {
        logic [STATE_W-1:0] from;
        logic [STATE_W-1:0] to;
        logic [COUNT_W-1:0] dwell;
    } log_entry_t;

    // Increment that sticks at the all-ones value of a w-bit counter.
    // Carried on 32 bits so any counter up to 32 bits wide can share it.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fsm_state_monitor_if.sv
// Transition-log drain channel between the state monitor and its consumer (debug/CSR block).
// Latency: wires only.
// Backpressure: log_valid/log_ready; head entry held stable while valid and not ready.
// Ports: log_valid, log_from, log_to, log_dwell (monitor -> consumer); log_ready (consumer -> monitor).
interface fsm_state_monitor_if
    import fsm_monitor_pkg::*;
#(
    parameter int STATE_WIDTH = STATE_W,
    parameter int COUNT_WIDTH = COUNT_W
);
    logic                   log_valid;
    logic                   log_ready;
    logic [STATE_WIDTH-1:0] log_from;
    logic [STATE_WIDTH-1:0] log_to;
    logic [COUNT_WIDTH-1:0] log_dwell;

    modport master (
        output log_valid,
        output log_from,
        output log_to,
        output log_dwell,
        input  log_ready
    );

    modport slave (
        input  log_valid,
        input  log_from,
        input  log_to,
        input  log_dwell,
        output log_ready
    );
endinterface

// File: rtl/fsm_log_fifo.sv
// Synchronous FIFO of transition records with flush.
// Latency: 1 cycle push-to-valid, no bypass; pop takes effect at the clock edge.
// Backpressure: push dropped when full unless a pop happens on the same edge; flush discards everything including a same-cycle push.
// Ports: clk, rst (async active-low), push_vld/push_dat/full, pop_vld/pop_rdy/pop_dat, flush.
module fsm_log_fifo
    import fsm_monitor_pkg::*;
#(
    parameter type entry_t = log_entry_t,
    parameter int  DEPTH   = LOG_DEPTH_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_vld,
    input  entry_t push_dat,
    output logic   full,
    output logic   pop_vld,
    input  logic   pop_rdy,
    output entry_t pop_dat,
    input  logic   flush
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    entry_t      mem [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        empty;
    logic        pop_fire;
    logic        push_fire;

    // Extra pointer MSB tells a full ring from an empty one.
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_vld   = !empty;
    assign pop_fire  = pop_vld && pop_rdy;
    // When full, a simultaneous pop frees the slot the push is about to fill.
    assign push_fire = push_vld && !flush && (!full || pop_fire);

    // Head is forced to zero while empty so the record outputs read 0 out of reset.
    assign pop_dat = pop_vld ? mem[rd_q[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_fire) wr_q <= wr_q + PTR_ONE;
            if (pop_fire)  rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_q[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/fsm_state_monitor.sv
// Watches a registered FSM state: dwell/transition counters, sticky timeout and overflow, transition log FIFO.
// Latency: change seen the cycle the new state is visible; its log record is valid one cycle later.
// Backpressure: log drained via valid/ready; records arriving at a full log are dropped and flagged in overflow.
// Ports: clk, rst (async active-low), state, clear, timeout_limit, dwell_count, transition_count,
//        timeout, timeout_state, overflow, log_if (master: log_valid/log_ready/log_from/log_to/log_dwell).
module fsm_state_monitor
    import fsm_monitor_pkg::*;
#(
    parameter int                     STATE_WIDTH = STATE_W,
    parameter int                     COUNT_WIDTH = COUNT_W,   // up to 32
    parameter int                     LOG_DEPTH   = LOG_DEPTH_DEF,
    parameter logic [STATE_WIDTH-1:0] RESET_STATE = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STATE_WIDTH-1:0] state,
    input  logic                   clear,
    input  logic [COUNT_WIDTH-1:0] timeout_limit,
    output logic [COUNT_WIDTH-1:0] dwell_count,
    output logic [COUNT_WIDTH-1:0] transition_count,
    output logic                   timeout,
    output logic [STATE_WIDTH-1:0] timeout_state,
    output logic                   overflow,
    fsm_state_monitor_if.master    log_if
);
    // Record type sized from this instance's parameters rather than package defaults.
    typedef struct packed {
        logic [STATE_WIDTH-1:0] from;
        logic [STATE_WIDTH-1:0] to;
        logic [COUNT_WIDTH-1:0] dwell;
    } entry_t;

    logic [STATE_WIDTH-1:0] prev_q;
    logic [COUNT_WIDTH-1:0] dwell_q, dwell_d;
    logic [COUNT_WIDTH-1:0] trans_q, trans_d;
    logic                   timeout_q, timeout_d;
    logic [STATE_WIDTH-1:0] tstate_q, tstate_d;
    logic                   overflow_q, overflow_d;
    logic                   change;
    logic                   timeout_hit;
    logic [COUNT_WIDTH:0]   dwell_plus1;
    logic                   fifo_full;
    logic                   fifo_vld;
    logic                   fifo_pop;
    entry_t                 push_dat;
    entry_t                 head_dat;

    assign change   = (state != prev_q);
    assign fifo_pop = fifo_vld && log_if.log_ready;

    // One bit wider so a saturated dwell can never wrap onto a small limit.
    assign dwell_plus1 = {1'b0, dwell_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    // Exact-equality compare: lowering the limit below the current dwell
    // does not fire until the next visit.
    assign timeout_hit = !change && (timeout_limit != '0) && !timeout_q &&
                         (dwell_plus1 == {1'b0, timeout_limit});

    // The record carries the dwell of the state being left, before it is zeroed.
    assign push_dat = '{from: prev_q, to: state, dwell: dwell_q};

    always_comb begin
        dwell_d    = dwell_q;
        trans_d    = trans_q;
        timeout_d  = timeout_q;
        tstate_d   = tstate_q;
        overflow_d = overflow_q;

        if (change) dwell_d = '0;
        else        dwell_d = COUNT_WIDTH'(sat_inc(32'(dwell_q), COUNT_WIDTH));

        if (clear) begin
            trans_d    = '0;
            timeout_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (change) trans_d = COUNT_WIDTH'(sat_inc(32'(trans_q), COUNT_WIDTH));
            if (timeout_hit) begin
                timeout_d = 1'b1;
                tstate_d  = state;
            end
            if (change && fifo_full && !fifo_pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q     <= RESET_STATE;
            dwell_q    <= '0;
            trans_q    <= '0;
            timeout_q  <= 1'b0;
            tstate_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= state;
            dwell_q    <= dwell_d;
            trans_q    <= trans_d;
            timeout_q  <= timeout_d;
            tstate_q   <= tstate_d;
            overflow_q <= overflow_d;
        end
    end

    fsm_log_fifo #(
        .entry_t (entry_t),
        .DEPTH   (LOG_DEPTH)
    ) u_log_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (change),
        .push_dat (push_dat),
        .full     (fifo_full),
        .pop_vld  (fifo_vld),
        .pop_rdy  (log_if.log_ready),
        .pop_dat  (head_dat),
        .flush    (clear)
    );

    assign dwell_count      = dwell_q;
    assign transition_count = trans_q;
    assign timeout          = timeout_q;
    assign timeout_state    = tstate_q;
    assign overflow         = overflow_q;

    assign log_if.log_valid = fifo_vld;
    assign log_if.log_from  = head_dat.from;
    assign log_if.log_to    = head_dat.to;
    assign log_if.log_dwell = head_dat.dwell;
endmodule
